id_queue: RTL and testbench

Registered, parametrised instruction-decode stage between fetch and executrol. Accepts one instruction per cycle from fetch over a valid/ready handshake, decodes RV32I + Zicsr + FENCE/ECALL/EBREAK into a control bundle, and buffers decoded entries in a DEPTH-entry FIFO. Executrol drains the FIFO over a second valid/ready handshake. Adds three things on top of a combinational decoder:
- back-pressure buffering,
- illegal-instruction flagging,
- a single-cycle flush for branch redirects.

---
 rtl/id_queue.sv | 256 +++++++++++++++++++++++++
 tb/tb_id_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_queue.sv
// RV32I + Zicsr decode stage: decodes the fetched word combinationally and buffers
// the decoded bundle in a DEPTH-entry FIFO drained by executrol; a flush empties it in one cycle.
module id_queue #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [4:0]        rs1_raddr_o,
    output logic [4:0]        rs2_raddr_o,
    output logic [4:0]        rd_waddr_o,
    output logic              rd_we_o,
    output logic [11:0]       csr_addr_o,
    output logic [31:0]       imm_o,
    output logic [3:0]        alu_sel_o,
    output logic [1:0]        op1_sel_o,
    output logic [1:0]        op2_sel_o,
    output logic [1:0]        mem_rw_o,
    output logic [3:0]        br_sel_o,
    output logic [2:0]        wb_sel_o,
    output logic [2:0]        byte_sel_o,
    output logic              illegal_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [1:0] OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_ZERO = 2'd2;
    localparam logic [1:0] OP2_RS2 = 2'd0, OP2_IMM = 2'd1, OP2_FOUR = 2'd2;
    localparam logic [1:0] MEM_DISABLE = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2;
    localparam logic [3:0] BR_DISABLE = 4'd0, BR_BEQ = 4'd1, BR_BNE = 4'd2, BR_BLT = 4'd3,
                           BR_BGE = 4'd4, BR_BLTU = 4'd5, BR_BGEU = 4'd6, BR_JAL = 4'd7,
                           BR_JALR = 4'd8;
    localparam logic [2:0] WB_NONE = 3'd0, WB_ALU = 3'd1, WB_MEM = 3'd2, WB_PC4 = 3'd3,
                           WB_CSR = 3'd4;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] addr;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              rd_we;
        logic [11:0]       csr;
        logic [31:0]       imm;
        logic [3:0]        alu;
        logic [1:0]        op1;
        logic [1:0]        op2;
        logic [1:0]        mem;
        logic [3:0]        br;
        logic [2:0]        wb;
        logic [2:0]        bsel;
        logic              illegal;
    } entry_t;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic is_op);
        case (f3)
            3'b000:  alu_of = (alt && is_op) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        use_rs1, use_rs2, ill;
    entry_t      dec;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'h000};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec      = '0;
        dec.inst = inst;
        dec.addr = inst_addr;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        ill      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.rd_we = 1'b1; dec.imm = imm_u; dec.op1 = OP1_ZERO; dec.op2 = OP2_IMM;
                dec.wb = WB_ALU;
            end
            OPC_AUIPC: begin
                dec.rd_we = 1'b1; dec.imm = imm_u; dec.op1 = OP1_PC; dec.op2 = OP2_IMM;
                dec.wb = WB_ALU;
            end
            OPC_JAL: begin
                dec.rd_we = 1'b1; dec.imm = imm_j; dec.op1 = OP1_PC; dec.op2 = OP2_FOUR;
                dec.br = BR_JAL; dec.wb = WB_PC4;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; dec.rd_we = 1'b1; dec.imm = imm_i; dec.op2 = OP2_IMM;
                dec.br = BR_JALR; dec.wb = WB_PC4;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_b; dec.alu = ALU_SUB;
                dec.op1 = OP1_RS1; dec.op2 = OP2_RS2;
                case (funct3)
                    3'b000:  dec.br = BR_BEQ;
                    3'b001:  dec.br = BR_BNE;
                    3'b100:  dec.br = BR_BLT;
                    3'b101:  dec.br = BR_BGE;
                    3'b110:  dec.br = BR_BLTU;
                    3'b111:  dec.br = BR_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; dec.rd_we = 1'b1; dec.imm = imm_i; dec.op2 = OP2_IMM;
                dec.mem = MEM_READ; dec.wb = WB_MEM; dec.bsel = funct3;
                if (funct3 == 3'b011 || funct3[2:1] == 2'b11) ill = 1'b1;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_s; dec.op2 = OP2_IMM;
                dec.mem = MEM_WRITE; dec.bsel = funct3;
                if (funct3 > 3'b010) ill = 1'b1;
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1; dec.rd_we = 1'b1; dec.imm = imm_i; dec.op2 = OP2_IMM;
                dec.wb = WB_ALU; dec.alu = alu_of(funct3, funct7[5], 1'b0);
                if (funct3 == 3'b001 && funct7 != 7'b0000000) ill = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) ill = 1'b1;
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.rd_we = 1'b1; dec.op2 = OP2_RS2;
                dec.wb = WB_ALU; dec.alu = alu_of(funct3, funct7[5], 1'b1);
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000) ill = 1'b1;
                if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101) ill = 1'b1;
            end
            OPC_FENCE: ;
            OPC_SYSTEM: begin
                case (funct3)
                    3'b000:  if (inst != 32'h0000_0073 && inst != 32'h0010_0073) ill = 1'b1;
                    3'b100:  ill = 1'b1;
                    default: begin
                        // csrrw/csrrs/csrrc read rs1; the immediate forms carry zimm there instead
                        use_rs1 = ~funct3[2]; dec.rd_we = 1'b1; dec.wb = WB_CSR;
                        dec.csr = inst[31:20];
                    end
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (inst[1:0] != 2'b11)
            ill = 1'b1;
        dec.rs1 = use_rs1 ? inst[19:15] : ZERO_REG;
        dec.rs2 = use_rs2 ? inst[24:20] : ZERO_REG;
        if (ill) begin
            dec.rd_we = 1'b0;
            dec.mem   = MEM_DISABLE;
            dec.br    = BR_DISABLE;
            dec.wb    = WB_NONE;
        end
        dec.rd      = dec.rd_we ? inst[11:7] : ZERO_REG;
        dec.illegal = ill;
    end

    logic [PTR_W-1:0] wptr_reg, rptr_reg;
    logic [LVL_W-1:0] count_reg;
    logic             push, pop;
    entry_t           store [DEPTH];
    entry_t           head;

    assign in_ready  = (count_reg < LVL_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            entry_t entry_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    entry_reg <= '0;
                else if (push && wptr_reg == PTR_W'(gi))
                    entry_reg <= dec;
            end
            assign store[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
        end else if (flush) begin
            count_reg <= '0;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
        end else begin
            if (push) wptr_reg <= ptr_inc(wptr_reg);
            if (pop)  rptr_reg <= ptr_inc(rptr_reg);
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    assign head        = store[rptr_reg];
    assign inst_o      = head.inst;
    assign inst_addr_o = head.addr;
    assign rs1_raddr_o = head.rs1;
    assign rs2_raddr_o = head.rs2;
    assign rd_waddr_o  = head.rd;
    assign rd_we_o     = head.rd_we;
    assign csr_addr_o  = head.csr;
    assign imm_o       = head.imm;
    assign alu_sel_o   = head.alu;
    assign op1_sel_o   = head.op1;
    assign op2_sel_o   = head.op2;
    assign mem_rw_o    = head.mem;
    assign br_sel_o    = head.br;
    assign wb_sel_o    = head.wb;
    assign byte_sel_o  = head.bsel;
    assign illegal_o   = head.illegal;
    assign level_o     = count_reg;
endmodule

// File: tb/tb_id_queue.sv
// Directed bench for id_queue (DEPTH = 2): decode fields, back-pressure, streaming,
// immediates, illegal encodings, flush and asynchronous reset.
module tb_id_queue;
    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;

    localparam logic [31:0] ALU_ADD = 0, ALU_SRA = 7, MEM_DISABLE = 0, MEM_WRITE = 2,
                            BR_BEQ = 1, BR_JAL = 7, WB_NONE = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       inst = '0;
    logic [ADDR_W-1:0] inst_addr = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic [4:0]        rs1_raddr_o, rs2_raddr_o, rd_waddr_o;
    logic              rd_we_o;
    logic [11:0]       csr_addr_o;
    logic [31:0]       imm_o;
    logic [3:0]        alu_sel_o;
    logic [1:0]        op1_sel_o, op2_sel_o, mem_rw_o;
    logic [3:0]        br_sel_o;
    logic [2:0]        wb_sel_o, byte_sel_o;
    logic              illegal_o;
    logic [1:0]        level_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .inst_addr(inst_addr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .rs1_raddr_o(rs1_raddr_o),
        .rs2_raddr_o(rs2_raddr_o), .rd_waddr_o(rd_waddr_o), .rd_we_o(rd_we_o),
        .csr_addr_o(csr_addr_o), .imm_o(imm_o), .alu_sel_o(alu_sel_o), .op1_sel_o(op1_sel_o),
        .op2_sel_o(op2_sel_o), .mem_rw_o(mem_rw_o), .br_sel_o(br_sel_o), .wb_sel_o(wb_sel_o),
        .byte_sel_o(byte_sel_o), .illegal_o(illegal_o), .level_o(level_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] w, input logic [31:0] a);
        in_valid = 1'b1; inst = w; inst_addr = a;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        logic [31:0] w;
        w = 32'h13;
        w[11:7] = 5'(rd);
        w[31:20] = 12'(imm);
        return w;
    endfunction

    initial begin
        // reset state (asserted from time 0)
        #3;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_level", 32'(level_o), 0);
        check("rst_inst_o", inst_o, 0);
        check("rst_illegal", 32'(illegal_o), 0);
        #9 rst = 1'b0;
        #4;

        // single addi x1,x0,5
        push_one(32'h0050_0093, 32'h100);
        check("addi_valid", 32'(out_valid), 1);
        check("addi_rd", 32'(rd_waddr_o), 1);
        check("addi_rd_we", 32'(rd_we_o), 1);
        check("addi_rs1", 32'(rs1_raddr_o), 0);
        check("addi_imm", imm_o, 32'h5);
        check("addi_alu", 32'(alu_sel_o), ALU_ADD);
        check("addi_illegal", 32'(illegal_o), 0);
        check("addi_level", 32'(level_o), 1);
        check("addi_addr", inst_addr_o, 32'h100);
        pop_one();
        check("addi_drained", 32'(level_o), 0);

        // fill and back-pressure
        in_valid = 1'b1; inst = addi(1, 1); tick();
        check("fill1_level", 32'(level_o), 1);
        check("fill1_ready", 32'(in_ready), 1);
        inst = addi(2, 2); tick();
        check("fill2_level", 32'(level_o), 2);
        check("fill2_ready", 32'(in_ready), 0);
        inst = addi(3, 3); tick();
        check("held_level", 32'(level_o), 2);
        check("held_head", inst_o, addi(1, 1));
        out_ready = 1'b1; tick();
        check("bp_pop1_head", inst_o, addi(2, 2));
        check("bp_pop1_level", 32'(level_o), 1);
        tick();
        in_valid = 1'b0;
        check("bp_pop2_head", inst_o, addi(3, 3));
        check("bp_pop2_level", 32'(level_o), 1);
        tick();
        out_ready = 1'b0;
        check("bp_empty", 32'(out_valid), 0);

        // streaming 8 instructions
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inst = addi(i + 4, i * 3);
            tick();
            check("stream_valid", 32'(out_valid), 1);
            check("stream_head", inst_o, addi(i + 4, i * 3));
            check("stream_level", 32'(level_o), 1);
        end
        in_valid = 1'b0; tick(); out_ready = 1'b0;
        check("stream_done", 32'(level_o), 0);

        // immediates and a store
        push_one(32'hFE00_0EE3, 32'h200);
        check("beq_imm", imm_o, 32'hFFFF_FFFC);
        check("beq_br", 32'(br_sel_o), BR_BEQ);
        check("beq_rd_we", 32'(rd_we_o), 0);
        pop_one();
        push_one(32'h0040_006F, 32'h204);
        check("jal_imm", imm_o, 32'h4);
        check("jal_br", 32'(br_sel_o), BR_JAL);
        pop_one();
        push_one(32'h1234_50B7, 32'h208);
        check("lui_imm", imm_o, 32'h1234_5000);
        check("lui_rd", 32'(rd_waddr_o), 1);
        pop_one();
        push_one(32'h0020_A423, 32'h20C);
        check("sw_imm", imm_o, 32'h8);
        check("sw_mem", 32'(mem_rw_o), MEM_WRITE);
        check("sw_rs2", 32'(rs2_raddr_o), 2);
        check("sw_rd", 32'(rd_waddr_o), 0);
        pop_one();
        push_one(32'h4000_D093, 32'h210);
        check("srai_legal", 32'(illegal_o), 0);
        check("srai_alu", 32'(alu_sel_o), ALU_SRA);
        pop_one();
        push_one(32'h0000_0073, 32'h214);
        check("ecall_legal", 32'(illegal_o), 0);
        pop_one();

        // illegal encodings
        push_one(32'h0000_007F, 32'h300);
        check("ill_opc", 32'(illegal_o), 1);
        check("ill_opc_we", 32'(rd_we_o), 0);
        check("ill_opc_mem", 32'(mem_rw_o), MEM_DISABLE);
        pop_one();
        push_one(32'h4200_D093, 32'h304);
        check("ill_srai", 32'(illegal_o), 1);
        check("ill_srai_we", 32'(rd_we_o), 0);
        check("ill_srai_rd", 32'(rd_waddr_o), 0);
        check("ill_srai_wb", 32'(wb_sel_o), WB_NONE);
        check("ill_srai_inst", inst_o, 32'h4200_D093);
        pop_one();
        push_one(32'h0020_0073, 32'h308);
        check("ill_sys", 32'(illegal_o), 1);
        check("ill_sys_mem", 32'(mem_rw_o), MEM_DISABLE);
        pop_one();

        // flush with two buffered plus incoming
        push_one(addi(10, 10), 32'h400);
        push_one(addi(11, 11), 32'h404);
        check("pre_flush_level", 32'(level_o), 2);
        in_valid = 1'b1; inst = addi(12, 12); out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_valid", 32'(out_valid), 0);
        check("flush_level", 32'(level_o), 0);
        check("flush_ready", 32'(in_ready), 1);
        tick();
        check("flush_stays_empty", 32'(out_valid), 0);
        // flush with room: incoming push must be dropped
        push_one(addi(13, 13), 32'h408);
        in_valid = 1'b1; inst = addi(14, 14); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_drop_level", 32'(level_o), 0);
        push_one(addi(15, 15), 32'h40C);
        check("post_flush_head", inst_o, addi(15, 15));
        check("post_flush_level", 32'(level_o), 1);

        // asynchronous reset while full
        push_one(addi(16, 16), 32'h410);
        check("full_level", 32'(level_o), 2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_level", 32'(level_o), 0);
        check("arst_ready", 32'(in_ready), 1);
        check("arst_inst", inst_o, 0);
        check("arst_imm", imm_o, 0);
        #1 rst = 1'b0;
        tick();
        push_one(addi(17, 17), 32'h500);
        check("after_rst_head", inst_o, addi(17, 17));
        check("after_rst_level", 32'(level_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
